branch_resolve_unit: RTL and testbench

//  Registered branch/jump resolution stage for the RV32I execute path. Takes a one-hot

---
 rtl/branch_resolve_unit_if.sv | 37 +++
 rtl/branch_resolve_unit.sv | 179 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Issue, resolution and fetch-redirect signals of branch_resolve_unit.
// slave = the resolve unit, master = the issue/fetch side driving it.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            i_Valid_1;
    logic            o_Ready_1;
    logic [7:0]      i_JumpCode_8;
    logic [XLEN-1:0] i_Src1_X;
    logic [XLEN-1:0] i_Src2_X;
    logic [XLEN-1:0] i_Pc_X;
    logic [XLEN-1:0] i_Imm_X;
    logic            i_PredTaken_1;
    logic [XLEN-1:0] i_PredTarget_X;
    logic            i_Flush_1;
    logic            o_ResValid_1;
    logic            o_Taken_1;
    logic [XLEN-1:0] o_LinkPc_X;
    logic            o_Misalign_1;
    logic            o_RedirValid_1;
    logic            i_RedirReady_1;
    logic [XLEN-1:0] o_RedirPc_X;

    modport slave (
        input  i_Valid_1, i_JumpCode_8, i_Src1_X, i_Src2_X, i_Pc_X, i_Imm_X,
               i_PredTaken_1, i_PredTarget_X, i_Flush_1, i_RedirReady_1,
        output o_Ready_1, o_ResValid_1, o_Taken_1, o_LinkPc_X, o_Misalign_1,
               o_RedirValid_1, o_RedirPc_X
    );

    modport master (
        output i_Valid_1, i_JumpCode_8, i_Src1_X, i_Src2_X, i_Pc_X, i_Imm_X,
               i_PredTaken_1, i_PredTarget_X, i_Flush_1, i_RedirReady_1,
        input  o_Ready_1, o_ResValid_1, o_Taken_1, o_LinkPc_X, o_Misalign_1,
               o_RedirValid_1, o_RedirPc_X
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// RV32I branch/jump resolve stage: registers one op, resolves it the next cycle and holds
// any fetch redirect until accepted. Define BRU_PERF_CNT_EN to add branch/mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN  = 32
`ifdef BRU_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                  i_Clk_1,
    input  logic                  i_Rstn_1,
`ifdef BRU_PERF_CNT_EN
    output logic [CNT_W-1:0]      o_BrCnt_C,
    output logic [CNT_W-1:0]      o_MispCnt_C,
`endif
    branch_resolve_unit_if.slave  bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_HOLD} state_e;

    state_e          state_q, state_d;
    logic [7:0]      code_q, code_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            pred_taken_q, pred_taken_d;
    logic [XLEN-1:0] pred_target_q, pred_target_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    logic            accept;
    logic            eval_live;
    logic            redir_issue;
    logic            is_eq, is_lt, is_ltu;
    logic            taken;
    logic            misalign_hit;
    logic            mispredict;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_pc;
    logic [XLEN-1:0] next_pc;

    assign accept = bus.i_Valid_1 & (state_q == ST_IDLE) & ~bus.i_Flush_1;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        code_d        = code_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (accept) begin
            code_d        = bus.i_JumpCode_8;
            src1_d        = bus.i_Src1_X;
            src2_d        = bus.i_Src2_X;
            pc_d          = bus.i_Pc_X;
            imm_d         = bus.i_Imm_X;
            pred_taken_d  = bus.i_PredTaken_1;
            pred_target_d = bus.i_PredTarget_X;
        end
    end

    assign is_eq   = (src1_q == src2_q);
    assign is_lt   = ($signed(src1_q) < $signed(src2_q));
    assign is_ltu  = (src1_q < src2_q);
    assign link_pc = pc_q + XLEN'(4);

    // Priority chain: the highest set jump-code bit decides, an all-zero code is not taken.
    always_comb begin
        taken  = 1'b0;
        target = pc_q + imm_q;
        if (code_q[7]) begin
            taken = 1'b1;
        end else if (code_q[6]) begin
            taken  = 1'b1;
            target = (src1_q + imm_q) & {{(XLEN-1){1'b1}}, 1'b0};
        end else if (code_q[5]) begin
            taken = is_eq;
        end else if (code_q[4]) begin
            taken = ~is_eq;
        end else if (code_q[3]) begin
            taken = is_lt;
        end else if (code_q[2]) begin
            taken = is_ltu;
        end else if (code_q[1]) begin
            taken = ~is_lt;
        end else if (code_q[0]) begin
            taken = ~is_ltu;
        end
    end

    assign next_pc      = taken ? target : link_pc;
    assign misalign_hit = taken & (target[1:0] != 2'b00);
    assign mispredict   = (taken != pred_taken_q) | (taken & (target != pred_target_q));

    // A flush or a reset arriving during EVAL kills every result of that cycle.
    assign eval_live   = (state_q == ST_EVAL) & ~bus.i_Flush_1 & i_Rstn_1;
    assign redir_issue = eval_live & mispredict & ~misalign_hit;

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                state_d = ST_IDLE;
                if (redir_issue) begin
                    redir_pc_d = next_pc;
                    if (!bus.i_RedirReady_1) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.i_Flush_1 || bus.i_RedirReady_1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk_1) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!i_Rstn_1) begin
            state_q       <= ST_IDLE;
            code_q        <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            pc_q          <= '0;
            imm_q         <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign bus.o_Ready_1      = (state_q == ST_IDLE);
    assign bus.o_ResValid_1   = eval_live;
    assign bus.o_Taken_1      = eval_live & taken;
    assign bus.o_LinkPc_X     = eval_live ? link_pc : '0;
    assign bus.o_Misalign_1   = eval_live & misalign_hit;
    assign bus.o_RedirValid_1 = redir_issue | (state_q == ST_HOLD);
    assign bus.o_RedirPc_X    = redir_issue            ? next_pc    :
                                (state_q == ST_HOLD)   ? redir_pc_q : '0;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;

    always_comb begin
        br_cnt_d   = br_cnt_q + CNT_W'(eval_live);
        misp_cnt_d = misp_cnt_q + CNT_W'(redir_issue);
    end

    always_ff @(posedge i_Clk_1) begin
        if (!i_Rstn_1) begin
            br_cnt_q   <= '0;
            misp_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign o_BrCnt_C   = br_cnt_q;
    assign o_MispCnt_C = misp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a per-op reference model sets the expected outputs
// of every cycle, one negedge process compares them, and literal checks pin the model.
module tb_branch_resolve_unit;

    logic clk;
    logic rstn;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt;
    logic [31:0] misp_cnt;
    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .i_Clk_1     (clk),
        .i_Rstn_1    (rstn),
        .o_BrCnt_C   (br_cnt),
        .o_MispCnt_C (misp_cnt),
        .bus         (bus)
    );
`else
    branch_resolve_unit #(.XLEN(32)) dut (
        .i_Clk_1  (clk),
        .i_Rstn_1 (rstn),
        .bus      (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          taken;
        logic [31:0] target;
        logic [31:0] next_pc;
        bit          misalign;
        bit          redirect;
    } res_t;

    // What one op must resolve to, straight from the ISA rules.
    function automatic res_t model(input logic [7:0] code, input logic [31:0] s1, input logic [31:0] s2,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic pt, input logic [31:0] ptg);
        res_t   r;
        int     top;
        longint ss1, ss2, us1, us2;
        top = -1;
        for (int b = 0; b < 8; b++) if (code[b]) top = b;
        ss1 = longint'($signed(s1));
        ss2 = longint'($signed(s2));
        us1 = longint'({32'h0, s1});
        us2 = longint'({32'h0, s2});
        r.taken  = 1'b0;
        r.target = pc + imm;
        case (top)
            7: r.taken = 1'b1;
            6: begin r.taken = 1'b1; r.target = (s1 + imm) & 32'hFFFF_FFFE; end
            5: r.taken = (us1 == us2);
            4: r.taken = (us1 != us2);
            3: r.taken = (ss1 < ss2);
            2: r.taken = (us1 < us2);
            1: r.taken = (ss1 >= ss2);
            0: r.taken = (us1 >= us2);
            default: r.taken = 1'b0;
        endcase
        r.next_pc  = r.taken ? r.target : pc + 32'd4;
        r.misalign = r.taken && (r.target[1:0] != 2'b00);
        r.redirect = !r.misalign && ((r.taken != pt) || (r.taken && (r.target != ptg)));
        return r;
    endfunction

    bit          check_en = 1'b0;
    logic        e_ready, e_res_valid, e_taken, e_misalign, e_redir_valid;
    logic [31:0] e_link, e_redir_pc;
    int unsigned exp_br = 0, exp_misp = 0;

    logic        snap_taken, snap_misalign, snap_redir_valid;
    logic [31:0] snap_link, snap_redir_pc;

    task automatic expect_idle();
        e_ready = 1'b1; e_res_valid = 1'b0; e_taken = 1'b0; e_link = '0;
        e_misalign = 1'b0; e_redir_valid = 1'b0; e_redir_pc = '0;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("ready",       bus.o_Ready_1,      e_ready);
            check("res_valid",   bus.o_ResValid_1,   e_res_valid);
            check("taken",       bus.o_Taken_1,      e_taken);
            check("link_pc",     bus.o_LinkPc_X,     e_link);
            check("misalign",    bus.o_Misalign_1,   e_misalign);
            check("redir_valid", bus.o_RedirValid_1, e_redir_valid);
            check("redir_pc",    bus.o_RedirPc_X,    e_redir_pc);
`ifdef BRU_PERF_CNT_EN
            check("br_cnt",      br_cnt,             exp_br);
            check("misp_cnt",    misp_cnt,           exp_misp);
`endif
        end
    end

    // kill_eval: 0 none, 1 flush in EVAL, 2 reset in EVAL.
    // end_mode : 0 fetch accepts, 1 flush, 2 reset, applied after hold_n stalled HOLD cycles.
    task automatic run_branch(input logic [7:0] code, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic pt, input logic [31:0] ptg,
                              input int hold_n, input int end_mode, input int kill_eval);
        res_t m;
        bit   live;
        m    = model(code, s1, s2, pc, imm, pt, ptg);
        live = (kill_eval == 0);

        bus.i_Valid_1 = 1'b1; bus.i_JumpCode_8 = code;
        bus.i_Src1_X = s1; bus.i_Src2_X = s2; bus.i_Pc_X = pc; bus.i_Imm_X = imm;
        bus.i_PredTaken_1 = pt; bus.i_PredTarget_X = ptg;
        expect_idle();
        @(negedge clk);
        @(posedge clk); #1;

        bus.i_Valid_1 = 1'b0;
        bus.i_JumpCode_8 = '0; bus.i_Src1_X = '0; bus.i_Src2_X = '0; bus.i_Pc_X = '0; bus.i_Imm_X = '0;
        bus.i_PredTaken_1 = 1'b0; bus.i_PredTarget_X = '0;
        bus.i_Flush_1 = (kill_eval == 1);
        rstn = (kill_eval != 2);
        e_ready       = 1'b0;
        e_res_valid   = live;
        e_taken       = live && m.taken;
        e_link        = live ? pc + 32'd4 : 32'h0;
        e_misalign    = live && m.misalign;
        e_redir_valid = live && m.redirect;
        e_redir_pc    = (live && m.redirect) ? m.next_pc : 32'h0;
        @(negedge clk);
        snap_taken       = bus.o_Taken_1;
        snap_misalign    = bus.o_Misalign_1;
        snap_redir_valid = bus.o_RedirValid_1;
        snap_link        = bus.o_LinkPc_X;
        snap_redir_pc    = bus.o_RedirPc_X;
        @(posedge clk); #1;
        if (kill_eval == 2) begin
            exp_br = 0; exp_misp = 0;
        end else if (live) begin
            exp_br++;
            if (m.redirect) exp_misp++;
        end
        bus.i_Flush_1 = 1'b0;
        rstn = 1'b1;

        if (live && m.redirect) begin
            for (int k = 0; k <= hold_n; k++) begin
                e_ready = 1'b0; e_res_valid = 1'b0; e_taken = 1'b0; e_link = '0;
                e_misalign = 1'b0; e_redir_valid = 1'b1; e_redir_pc = m.next_pc;
                if (k == hold_n) begin
                    case (end_mode)
                        0:       bus.i_RedirReady_1 = 1'b1;
                        1:       bus.i_Flush_1 = 1'b1;
                        default: rstn = 1'b0;
                    endcase
                end
                @(negedge clk);
                @(posedge clk); #1;
                if (k == hold_n && end_mode == 2) begin
                    exp_br = 0; exp_misp = 0;
                end
            end
            bus.i_RedirReady_1 = 1'b0;
            bus.i_Flush_1 = 1'b0;
            rstn = 1'b1;
        end
        expect_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        bus.i_Valid_1 = 1'b0; bus.i_JumpCode_8 = '0; bus.i_Src1_X = '0; bus.i_Src2_X = '0;
        bus.i_Pc_X = '0; bus.i_Imm_X = '0; bus.i_PredTaken_1 = 1'b0; bus.i_PredTarget_X = '0;
        bus.i_Flush_1 = 1'b0; bus.i_RedirReady_1 = 1'b0;
        expect_idle();
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;

        // BEQ taken against a not-taken prediction, redirect stalled 3 cycles.
        run_branch(8'h20, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 32'h0, 3, 0, 0);
        check("beq_taken",    snap_taken,       1);
        check("beq_redir_pc", snap_redir_pc,    32'h120);
        check("beq_link",     snap_link,        32'h104);

        // Signed vs unsigned less-than on the same operands.
        run_branch(8'h08, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h10, 1'b1, 32'h310, 0, 0, 0);
        check("blt_taken",    snap_taken,       1);
        check("blt_no_redir", snap_redir_valid, 0);
        run_branch(8'h04, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h10, 1'b1, 32'h310, 0, 0, 0);
        check("bltu_taken",   snap_taken,       0);
        check("bltu_redir",   snap_redir_pc,    32'h304);

        // JALR to 0x1002: taken but misaligned, so a trap rather than a redirect.
        run_branch(8'h40, 32'h1003, 32'h0, 32'h400, 32'h0, 1'b1, 32'h1002, 0, 0, 0);
        check("jalr_link",     snap_link,        32'h404);
        check("jalr_misalign", snap_misalign,    1);
        run_branch(8'h40, 32'h1003, 32'h0, 32'h400, 32'h0, 1'b1, 32'h1000, 0, 0, 0);
        check("jalr_mis_noredir", snap_redir_valid, 0);

        // JALR clears bit 0 of an odd sum and redirects.
        run_branch(8'h40, 32'h2001, 32'h0, 32'h440, 32'h10, 1'b0, 32'h0, 1, 0, 0);
        check("jalr_lsb_redir", snap_redir_pc,  32'h2010);

        // JAL to a misaligned target.
        run_branch(8'h80, 32'h0, 32'h0, 32'h200, 32'h6, 1'b0, 32'h0, 0, 0, 0);
        check("jal_misalign", snap_misalign,    1);
        check("jal_no_redir", snap_redir_valid, 0);

        // BNE redirect held 3 cycles, then flushed away.
        run_branch(8'h10, 32'h1, 32'h2, 32'h500, 32'h40, 1'b0, 32'h0, 3, 1, 0);
        check("bne_redir_pc", snap_redir_pc,    32'h540);

        // Not-taken BNE with a stale predicted target is not a mispredict.
        run_branch(8'h10, 32'h5, 32'h5, 32'h520, 32'h40, 1'b0, 32'h1234, 0, 0, 0);
        check("bne_nt_noredir", snap_redir_valid, 0);

        // Empty code: only a taken prediction needs repair.
        run_branch(8'h00, 32'h0, 32'h0, 32'h600, 32'h8, 1'b1, 32'h600, 0, 0, 0);
        check("none_redir_pc", snap_redir_pc,   32'h604);
        run_branch(8'h00, 32'h0, 32'h0, 32'h600, 32'h8, 1'b0, 32'h0, 0, 0, 0);

        // Multi-hot BEQ|BGEU: BEQ (higher bit) decides, not taken.
        run_branch(8'h21, 32'h4, 32'h3, 32'h700, 32'h8, 1'b0, 32'h0, 0, 0, 0);
        check("multihot_taken", snap_taken,     0);

        // BGE / BGEU with 1 vs -1.
        run_branch(8'h02, 32'h1, 32'hFFFF_FFFF, 32'h800, 32'h10, 1'b1, 32'h810, 0, 0, 0);
        check("bge_taken",    snap_taken,       1);
        run_branch(8'h01, 32'h1, 32'hFFFF_FFFF, 32'h800, 32'h10, 1'b1, 32'h810, 0, 0, 0);
        check("bgeu_redir",   snap_redir_pc,    32'h804);

        // Taken as predicted but to the wrong target.
        run_branch(8'h20, 32'h9, 32'h9, 32'h900, 32'h100, 1'b1, 32'h904, 0, 0, 0);
        check("tgt_redir_pc", snap_redir_pc,    32'hA00);

        // Target and link wrap modulo 2^32.
        run_branch(8'h20, 32'h7, 32'h7, 32'hFFFF_FFF0, 32'h20, 1'b0, 32'h0, 1, 0, 0);
        check("wrap_redir",   snap_redir_pc,    32'h10);
        check("wrap_link",    snap_link,        32'hFFFF_FFF4);

        // Flush during EVAL, reset during EVAL, reset during HOLD.
        run_branch(8'h20, 32'h5, 32'h5, 32'hA00, 32'h4, 1'b0, 32'h0, 0, 0, 1);
        run_branch(8'h20, 32'h5, 32'h5, 32'hA00, 32'h4, 1'b0, 32'h0, 0, 0, 2);
        run_branch(8'h20, 32'h5, 32'h5, 32'hA00, 32'h4, 1'b0, 32'h0, 1, 2, 0);

        // Valid with flush in the same cycle is not accepted.
        bus.i_Valid_1 = 1'b1; bus.i_Flush_1 = 1'b1; bus.i_JumpCode_8 = 8'h80;
        bus.i_Pc_X = 32'hB00; bus.i_Imm_X = 32'h8;
        expect_idle();
        @(negedge clk);
        @(posedge clk); #1;
        bus.i_Valid_1 = 1'b0; bus.i_Flush_1 = 1'b0; bus.i_JumpCode_8 = '0;
        bus.i_Pc_X = '0; bus.i_Imm_X = '0;
        @(negedge clk);
        @(posedge clk); #1;

        // A normal op after all that still resolves.
        run_branch(8'h80, 32'h0, 32'h0, 32'hC00, 32'h40, 1'b0, 32'h0, 0, 0, 0);
        check("final_jal_redir", snap_redir_pc, 32'hC40);
        @(negedge clk);
        @(posedge clk); #1;
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
